// File: rtl/multiexp_stream_adapter.sv
// Ingress serialiser / egress packer around the multiexp core word stream.
// Define MULTIEXP_ADAPTER_CNT_EN to enable the completed-point counter o_pnt_cnt.
module multiexp_stream_adapter #(
    parameter int FE_BITS = 256,
    parameter int PNT_WORDS = 4,
    parameter int PNT_BEAT_WORDS = 2,
    parameter int Z_WORDS = 2,
    parameter logic [FE_BITS-1:0] ONE_WORD = FE_BITS'(1),
    parameter int RES_WORDS = 6,
    parameter int RES_PACK = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_scl_if_val,
    output logic                               i_scl_if_rdy,
    input  logic [FE_BITS-1:0]                 i_scl_if_dat,
    input  logic                               i_pnt_if_val,
    output logic                               i_pnt_if_rdy,
    input  logic [FE_BITS*PNT_BEAT_WORDS-1:0]  i_pnt_if_dat,
    output logic                               o_core_if_val,
    input  logic                               o_core_if_rdy,
    output logic [FE_BITS-1:0]                 o_core_if_dat,
    output logic                               o_core_if_sop,
    output logic                               o_core_if_eop,
    input  logic                               i_core_if_val,
    output logic                               i_core_if_rdy,
    input  logic [FE_BITS-1:0]                 i_core_if_dat,
    output logic                               o_res_if_val,
    input  logic                               o_res_if_rdy,
    output logic [FE_BITS*RES_PACK-1:0]        o_res_if_dat,
    output logic                               o_res_if_sop,
    output logic                               o_res_if_eop,
    output logic [63:0]                        o_pnt_cnt
);

    localparam int WW = (PNT_WORDS > 1) ? $clog2(PNT_WORDS) : 1;
    localparam int BW = (PNT_BEAT_WORDS > 1) ? $clog2(PNT_BEAT_WORDS) : 1;
    localparam int ZW = (Z_WORDS > 1) ? $clog2(Z_WORDS) : 1;
    localparam int KW = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
    localparam int PW = (RES_PACK > 1) ? $clog2(RES_PACK) : 1;

    typedef enum logic [1:0] {
        S_SCL,
        S_PNT,
        S_Z
    } state_t;

    state_t state, state_n;
    logic [WW-1:0] w, w_n;
    logic [BW-1:0] b, b_n;
    logic [ZW-1:0] z, z_n;
    logic [FE_BITS*PNT_BEAT_WORDS-1:0] pbuf;

    logic adv;
    logic load;
    logic buf_ld;
    logic [FE_BITS-1:0] ld_dat;
    logic ld_sop;
    logic ld_eop;
    logic scl_rdy;
    logic pnt_rdy;

    assign adv = ~o_core_if_val | o_core_if_rdy;
    assign i_scl_if_rdy = scl_rdy & ~i_rst;
    assign i_pnt_if_rdy = pnt_rdy & ~i_rst;

    always_comb begin
        state_n = state;
        w_n = w;
        b_n = b;
        z_n = z;
        load = 1'b0;
        buf_ld = 1'b0;
        ld_dat = '0;
        ld_sop = 1'b0;
        ld_eop = 1'b0;
        scl_rdy = 1'b0;
        pnt_rdy = 1'b0;
        unique case (state)
            S_SCL: begin
                scl_rdy = adv;
                if (adv && i_scl_if_val) begin
                    load = 1'b1;
                    ld_dat = i_scl_if_dat;
                    ld_sop = 1'b1;
                    state_n = S_PNT;
                    w_n = '0;
                    b_n = '0;
                end
            end
            S_PNT: begin
                // first word of each beat comes straight from the input
                if (b == '0) begin
                    pnt_rdy = adv;
                    if (adv && i_pnt_if_val) begin
                        load = 1'b1;
                        buf_ld = 1'b1;
                        ld_dat = i_pnt_if_dat[FE_BITS-1:0];
                    end
                end else if (adv) begin
                    load = 1'b1;
                    ld_dat = pbuf[b*FE_BITS +: FE_BITS];
                end
                if (load) begin
                    b_n = (b == BW'(PNT_BEAT_WORDS - 1)) ? '0 : b + 1'b1;
                    if (w == WW'(PNT_WORDS - 1)) begin
                        state_n = S_Z;
                        z_n = '0;
                    end else begin
                        w_n = w + 1'b1;
                    end
                end
            end
            S_Z: begin
                if (adv) begin
                    load = 1'b1;
                    ld_dat = (z == '0) ? ONE_WORD : '0;
                    if (z == ZW'(Z_WORDS - 1)) begin
                        ld_eop = 1'b1;
                        state_n = S_SCL;
                    end else begin
                        z_n = z + 1'b1;
                    end
                end
            end
            default: state_n = S_SCL;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_SCL;
            w <= '0;
            b <= '0;
            z <= '0;
            o_core_if_val <= 1'b0;
            o_core_if_sop <= 1'b0;
            o_core_if_eop <= 1'b0;
        end else begin
            state <= state_n;
            w <= w_n;
            b <= b_n;
            z <= z_n;
            if (load) begin
                o_core_if_val <= 1'b1;
                o_core_if_sop <= ld_sop;
                o_core_if_eop <= ld_eop;
            end else if (o_core_if_rdy) begin
                o_core_if_val <= 1'b0;
                o_core_if_sop <= 1'b0;
                o_core_if_eop <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (load) o_core_if_dat <= ld_dat;
        if (buf_ld) pbuf <= i_pnt_if_dat;
    end

    logic [KW-1:0] k;
    logic [PW-1:0] pk;
    logic core_hs;

    assign i_core_if_rdy = (~o_res_if_val | o_res_if_rdy) & ~i_rst;
    assign core_hs = i_core_if_val & i_core_if_rdy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            k <= '0;
            pk <= '0;
            o_res_if_val <= 1'b0;
            o_res_if_sop <= 1'b0;
            o_res_if_eop <= 1'b0;
        end else if (core_hs) begin
            k <= (k == KW'(RES_WORDS - 1)) ? '0 : k + 1'b1;
            if (pk == PW'(RES_PACK - 1)) begin
                pk <= '0;
                o_res_if_val <= 1'b1;
                o_res_if_sop <= (k == KW'(RES_PACK - 1));
                o_res_if_eop <= (k == KW'(RES_WORDS - 1));
            end else begin
                pk <= pk + 1'b1;
                if (o_res_if_rdy) begin
                    o_res_if_val <= 1'b0;
                    o_res_if_sop <= 1'b0;
                    o_res_if_eop <= 1'b0;
                end
            end
        end else if (o_res_if_rdy) begin
            o_res_if_val <= 1'b0;
            o_res_if_sop <= 1'b0;
            o_res_if_eop <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (core_hs) o_res_if_dat[pk*FE_BITS +: FE_BITS] <= i_core_if_dat;
    end

`ifdef MULTIEXP_ADAPTER_CNT_EN
    logic [63:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (o_core_if_val && o_core_if_rdy && o_core_if_eop) begin
            cnt <= cnt + 64'd1;
        end
    end

    assign o_pnt_cnt = cnt;
`else
    assign o_pnt_cnt = 64'd0;
`endif

endmodule
